sfr_read_port: RTL
==================

SFR_READ_PORT -- requirements
Module: sfr_read_port

Interface
REQ-001 SHALL have a clock port named clock, 1 bit, input, the single rising-edge clock for all state.
REQ-002 SHALL have a reset port named reset, 1 bit, input, asynchronous and active-high.
REQ-003 SHALL have inputs rd_en (1), rd_bit_en (1) and addr (8): the read request, the bit/byte select and the SFR byte or bit address.
REQ-004 SHALL have inputs wr_en (1), wr_bit_en (1), data_in (8) and bit_in (1): the core's SFR write bus, sampled for forwarding only.
REQ-005 SHALL have 8-bit inputs acc_data, b_data, psw_data, sp_data, dpl_data, dph_data, p0_data, p1_data, p2_data and p3_data: the current SFR values.
REQ-006 SHALL have outputs data_out (8), bit_out (1), parity (1), rd_valid (1) and busy (1).

Function
REQ-007 SHALL use the SFR addresses from define_opcodes.v: ACC E0h, B F0h, PSW D0h, SP 81h, DPL 82h, DPH 83h, P0 80h, P1 90h, P2 A0h, P3 B0h.
REQ-008 SHALL implement the FSM states IDLE, LATCH and VALID.
REQ-009 SHALL accept a request on a rising edge when rd_en=1 and the state is IDLE or VALID, register addr and rd_bit_en, and move to LATCH.
REQ-010 SHALL ignore rd_en while in LATCH, so busy=1 exactly when the state is LATCH; the core holds its request until busy=0.
REQ-011 SHALL derive the target byte in LATCH: for a byte read it is the registered addr; for a bit read it is addr & F8h, with bit index addr[2:0].
REQ-012 SHALL, on the edge leaving LATCH, capture the selected SFR value into data_out and enter VALID.
REQ-013 SHALL, on that same edge, set bit_out to data_out[idx] for a bit read and to 0 for a byte read.
REQ-014 SHALL assert rd_valid for exactly the one cycle spent in VALID, which is the second edge after acceptance (latency 2).
REQ-015 SHALL move from VALID to LATCH if a new request is accepted on that edge (back-to-back reads give one result every 2 cycles), and otherwise to IDLE.
REQ-016 SHALL hold data_out and bit_out until the next capture.
REQ-017 SHALL return a captured value of 00h, and bit_out 0, for an unmapped target byte.
REQ-018 SHALL drive parity combinationally as the XOR of the 8 bits of data_out.
REQ-019 SHALL capture the pre-edge SFR input value when a write and a capture coincide, unless REQ-023 applies.

Reset
REQ-020 SHALL, while reset=1 and regardless of clock, force the state to IDLE, data_out to 00h, bit_out to 0, rd_valid to 0 and busy to 0.
REQ-021 SHALL discard an in-flight request when reset is asserted mid-operation (LATCH or VALID), and SHALL NOT produce rd_valid for it after reset is released.
REQ-022 SHALL honour a request only on the first rising edge after reset deasserts, when rd_en=1 at that edge.

Configuration
REQ-023 SHALL, with SFR_RD_FWD_EN defined and in LATCH, forward a same-cycle write to the target byte into the captured value:
- byte write: wr_en=1, wr_bit_en=0 and addr equal to the target byte; data_in replaces the captured value.
- bit write: wr_en=1, wr_bit_en=1 and (addr & F8h) equal to the target byte; bit_in is merged at bit addr[2:0].
- bit_out and parity are derived from the forwarded value.
REQ-024 SHALL, without SFR_RD_FWD_EN, contain no forwarding logic; the wr_en, wr_bit_en, data_in and bit_in inputs remain present but are unused.

Verification
REQ-025 SHALL cover a byte read: acc_data=5Ah, rd_en=1 and addr=E0h for one cycle -> busy=1 for one cycle, then rd_valid=1 two edges after acceptance with data_out=5Ah and parity=0.
REQ-026 SHALL cover a bit read: psw_data=80h, rd_en=1, rd_bit_en=1 and addr=D7h -> data_out=80h, bit_out=1, parity=1.
REQ-027 SHALL cover back-to-back and unmapped reads: B then SP read requests held continuously -> rd_valid pulses every 2 cycles with the correct values; a read of addr=99h -> data_out=00h.
REQ-028 SHALL cover forwarding: a byte read of E0h with a write of data_in=33h to E0h in LATCH -> data_out=33h with SFR_RD_FWD_EN defined, and the old acc_data without it.
REQ-029 SHALL cover reset mid-operation: reset pulsed during LATCH -> all outputs 0, state IDLE, and no rd_valid afterwards until a new request is made.

Source files
------------

// File: rtl/sfr_read_port.sv
// Two-cycle SFR read port: accept -> LATCH (select target byte) -> VALID (result registered).
// Optional same-cycle write forwarding into the captured value when SFR_RD_FWD_EN is defined.
module sfr_read_port (
  input  logic       clock,
  input  logic       reset,
  input  logic       rd_en,
  input  logic       rd_bit_en,
  input  logic [7:0] addr,
  input  logic       wr_en,
  input  logic       wr_bit_en,
  input  logic [7:0] data_in,
  input  logic       bit_in,
  input  logic [7:0] acc_data,
  input  logic [7:0] b_data,
  input  logic [7:0] psw_data,
  input  logic [7:0] sp_data,
  input  logic [7:0] dpl_data,
  input  logic [7:0] dph_data,
  input  logic [7:0] p0_data,
  input  logic [7:0] p1_data,
  input  logic [7:0] p2_data,
  input  logic [7:0] p3_data,
  output logic [7:0] data_out,
  output logic       bit_out,
  output logic       parity,
  output logic       rd_valid,
  output logic       busy
);

  localparam logic [7:0] AddrAcc = 8'hE0;
  localparam logic [7:0] AddrB   = 8'hF0;
  localparam logic [7:0] AddrPsw = 8'hD0;
  localparam logic [7:0] AddrSp  = 8'h81;
  localparam logic [7:0] AddrDpl = 8'h82;
  localparam logic [7:0] AddrDph = 8'h83;
  localparam logic [7:0] AddrP0  = 8'h80;
  localparam logic [7:0] AddrP1  = 8'h90;
  localparam logic [7:0] AddrP2  = 8'hA0;
  localparam logic [7:0] AddrP3  = 8'hB0;

  typedef enum logic [1:0] {StIdle, StLatch, StValid} state_t;

  state_t     state_q;
  logic [7:0] addr_q;
  logic       bit_q;
  logic [7:0] target;
  logic [2:0] idx;
  logic [7:0] sel;
  logic [7:0] cap;

  // Bit addresses map onto the byte whose low three address bits are zero.
  always_comb begin
    target = bit_q ? (addr_q & 8'hF8) : addr_q;
    idx    = addr_q[2:0];
  end

  always_comb begin
    sel = 8'h00;
    case (target)
      AddrAcc: sel = acc_data;
      AddrB:   sel = b_data;
      AddrPsw: sel = psw_data;
      AddrSp:  sel = sp_data;
      AddrDpl: sel = dpl_data;
      AddrDph: sel = dph_data;
      AddrP0:  sel = p0_data;
      AddrP1:  sel = p1_data;
      AddrP2:  sel = p2_data;
      AddrP3:  sel = p3_data;
      default: sel = 8'h00;
    endcase
  end

`ifdef SFR_RD_FWD_EN
  // A write landing on the target byte in LATCH wins over the stale SFR input.
  always_comb begin
    cap = sel;
    if (wr_en && !wr_bit_en && (addr == target)) begin
      cap = data_in;
    end else if (wr_en && wr_bit_en && ((addr & 8'hF8) == target)) begin
      cap[addr[2:0]] = bit_in;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_bit_en, data_in, bit_in};
  assign cap = sel;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= 8'h00;
      bit_q    <= 1'b0;
      data_out <= 8'h00;
      bit_out  <= 1'b0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state_q)
        StIdle, StValid: begin
          if (rd_en) begin
            addr_q  <= addr;
            bit_q   <= rd_bit_en;
            busy    <= 1'b1;
            state_q <= StLatch;
          end else begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StLatch: begin
          data_out <= cap;
          bit_out  <= bit_q ? cap[idx] : 1'b0;
          rd_valid <= 1'b1;
          busy     <= 1'b0;
          state_q  <= StValid;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign parity = ^data_out;

endmodule
